jojo_hit_manager: RTL and testbench

//  Downstream consumer of the chasing-enemy sprite: samples per-pixel overlap of JoJo and enemy

---
 rtl/jojo_hit_manager_if.sv | 24 ++
 rtl/jojo_hit_manager.sv | 161 ++++++++++++++++
 tb/tb_jojo_hit_manager.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jojo_hit_manager_if.sv
// jojo_hit_manager_if: pixel-stream inputs and hit/HP status outputs of the
// JoJo hit manager. The master side is the video/sprite pipeline and the slave
// side is the hit manager itself.
interface jojo_hit_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       jojo_on;
  logic       mask_crazy_on;
  logic [3:0] hp;
  logic       hit_pulse;
  logic       invincible;
  logic       jojo_visible;
  logic       game_over;

  modport master (
    output x, y, jojo_on, mask_crazy_on,
    input  hp, hit_pulse, invincible, jojo_visible, game_over
  );

  modport slave (
    input  x, y, jojo_on, mask_crazy_on,
    output hp, hit_pulse, invincible, jojo_visible, game_over
  );
endinterface

// File: rtl/jojo_hit_manager.sv
// jojo_hit_manager: collects JoJo/enemy sprite overlap during active video,
// applies at most one hit per frame, and tracks HP, the post-hit invincibility
// window with its blink gate, and the sticky game-over state.
// Optional feature macro: JOJO_HEAL_EN (regain 1 HP after HEAL_FRAMES clean
// frames while alive and below HP_MAX).
module jojo_hit_manager #(
  parameter int HP_MAX      = 3,
  parameter int INV_FRAMES  = 60,
  parameter int BLINK_SHIFT = 2,
  parameter int HEAL_FRAMES = 300
) (
  input  logic       i_clk,
  input  logic       i_reset,
  jojo_hit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_INV   = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  localparam logic [3:0] HP_MAX_L   = 4'(HP_MAX);
  localparam logic [7:0] INV_LAST_L = 8'(INV_FRAMES - 1);

  state_t     r_state,       w_state_nxt;
  logic [3:0] r_hp,          w_hp_nxt;
  logic [7:0] r_inv_cnt,     w_inv_cnt_nxt;
  logic       r_hit_pulse,   w_hit_pulse_nxt;
  logic       r_origin;
  logic       r_latch;

  logic       w_origin;
  logic       w_frame_tick;
  logic       w_overlap;
  logic       w_hit_seen;
  logic       w_invincible;

`ifdef JOJO_HEAL_EN
  localparam int              HEAL_W      = $clog2(HEAL_FRAMES + 1);
  localparam logic [HEAL_W-1:0] HEAL_LAST_L = HEAL_W'(HEAL_FRAMES - 1);
  logic [HEAL_W-1:0] r_heal_cnt, w_heal_cnt_nxt;
`endif

  // Frame start is the first clock of a (0,0) pixel; holding that pixel for
  // several clocks must not produce extra ticks.
  assign w_origin     = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign w_frame_tick = w_origin && !r_origin;

  // Overlap only counts inside the 640x480 visible area.
  assign w_overlap    = bus.jojo_on && bus.mask_crazy_on &&
                        (bus.x < 10'd640) && (bus.y < 10'd480);

  // An overlap on the tick clock itself still belongs to the frame that ends.
  assign w_hit_seen   = r_latch || w_overlap;

  // Frame-edge detector and per-frame overlap latch.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_origin <= 1'b0;
      r_latch  <= 1'b0;
    end else begin
      r_origin <= w_origin;
      r_latch  <= w_frame_tick ? 1'b0 : (r_latch || w_overlap);
    end
  end

  // Hit/HP state machine: next-state and next-value logic, evaluated on ticks.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_hp_nxt        = r_hp;
    w_inv_cnt_nxt   = r_inv_cnt;
    w_hit_pulse_nxt = 1'b0;
`ifdef JOJO_HEAL_EN
    w_heal_cnt_nxt  = r_heal_cnt;
`endif

    unique case (r_state)
      ST_ALIVE: begin
        if (w_frame_tick) begin
          if (w_hit_seen) begin
            w_hit_pulse_nxt = 1'b1;
            w_hp_nxt        = (r_hp == 4'd0) ? 4'd0 : r_hp - 4'd1;
            w_inv_cnt_nxt   = 8'd0;
            w_state_nxt     = (r_hp <= 4'd1) ? ST_DEAD : ST_INV;
`ifdef JOJO_HEAL_EN
            w_heal_cnt_nxt  = '0;
          end else if (r_hp < HP_MAX_L) begin
            if (r_heal_cnt == HEAL_LAST_L) begin
              w_hp_nxt       = r_hp + 4'd1;
              w_heal_cnt_nxt = '0;
            end else begin
              w_heal_cnt_nxt = r_heal_cnt + 1'b1;
            end
          end else begin
            w_heal_cnt_nxt = '0;
`endif
          end
        end
      end

      ST_INV: begin
`ifdef JOJO_HEAL_EN
        w_heal_cnt_nxt = '0;
`endif
        if (w_frame_tick) begin
          if (r_inv_cnt == INV_LAST_L) begin
            w_state_nxt   = ST_ALIVE;
            w_inv_cnt_nxt = 8'd0;
          end else begin
            w_inv_cnt_nxt = r_inv_cnt + 8'd1;
          end
        end
      end

      ST_DEAD: begin
`ifdef JOJO_HEAL_EN
        w_heal_cnt_nxt = '0;
`endif
      end

      default: begin
        w_state_nxt = ST_ALIVE;
      end
    endcase
  end

  // Hit/HP state machine: state and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_ALIVE;
      r_hp        <= HP_MAX_L;
      r_inv_cnt   <= 8'd0;
      r_hit_pulse <= 1'b0;
`ifdef JOJO_HEAL_EN
      r_heal_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_hp        <= w_hp_nxt;
      r_inv_cnt   <= w_inv_cnt_nxt;
      r_hit_pulse <= w_hit_pulse_nxt;
`ifdef JOJO_HEAL_EN
      r_heal_cnt  <= w_heal_cnt_nxt;
`endif
    end
  end

  // Status outputs; JoJo blinks off for every other 2**BLINK_SHIFT frames.
  assign w_invincible     = (r_state == ST_INV);
  assign bus.hp           = r_hp;
  assign bus.hit_pulse    = r_hit_pulse;
  assign bus.invincible   = w_invincible;
  assign bus.jojo_visible = !w_invincible || !r_inv_cnt[BLINK_SHIFT];
  assign bus.game_over    = (r_state == ST_DEAD);

endmodule

// File: tb/tb_jojo_hit_manager.sv
// tb_jojo_hit_manager: drives short synthetic frames (origin pixel run plus a
// few random pixels) into jojo_hit_manager and compares every cycle against a
// frame-level model of HP, remaining invincibility frames and game-over.
module tb_jojo_hit_manager;

  localparam int HP_MAX      = 3;
  localparam int INV_FRAMES  = 60;
  localparam int BLINK_SHIFT = 2;
  localparam int HEAL_FRAMES = 300;
  localparam int NPIX        = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  jojo_hit_if bus ();

  jojo_hit_manager #(
    .HP_MAX      (HP_MAX),
    .INV_FRAMES  (INV_FRAMES),
    .BLINK_SHIFT (BLINK_SHIFT),
    .HEAL_FRAMES (HEAL_FRAMES)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int m_hp        = HP_MAX;
  int m_left      = 0;      // invincible frames still to go
  int m_clean     = 0;      // consecutive clean alive frames below max HP
  bit m_dead      = 0;
  bit m_pulse     = 0;
  bit m_frame_hit = 0;
  bit m_was_origin = 0;
  bit cmp_en      = 0;

  function automatic bit m_visible();
    int elapsed;
    if (m_left == 0) return 1'b1;
    elapsed = INV_FRAMES - m_left;
    return ((elapsed / (1 << BLINK_SHIFT)) % 2) == 0;
  endfunction

  task automatic model_edge(bit rst, int x, int y, bit j, bit m);
    bit origin, tick, ov, hit;
    if (rst) begin
      m_hp = HP_MAX; m_left = 0; m_clean = 0; m_dead = 0;
      m_pulse = 0; m_frame_hit = 0; m_was_origin = 0;
      return;
    end
    origin       = (x == 0) && (y == 0);
    tick         = origin && !m_was_origin;
    m_was_origin = origin;
    ov           = j && m && (x < 640) && (y < 480);
    m_pulse      = 0;
    if (!tick) begin
      m_frame_hit = m_frame_hit || ov;
      return;
    end
    hit         = m_frame_hit || ov;
    m_frame_hit = 0;
    if (m_dead) return;
    if (m_left > 0) begin
      m_left  = m_left - 1;
      m_clean = 0;
      return;
    end
    if (hit) begin
      m_hp    = m_hp - 1;
      m_pulse = 1;
      m_clean = 0;
      if (m_hp == 0) m_dead = 1;
      else           m_left = INV_FRAMES;
    end else begin
`ifdef JOJO_HEAL_EN
      if (m_hp < HP_MAX) begin
        m_clean = m_clean + 1;
        if (m_clean == HEAL_FRAMES) begin
          m_hp    = m_hp + 1;
          m_clean = 0;
        end
      end else begin
        m_clean = 0;
      end
`endif
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_hp",           int'(bus.hp),           m_hp);
      check("cyc_hit_pulse",    int'(bus.hit_pulse),    int'(m_pulse));
      check("cyc_invincible",   int'(bus.invincible),   int'(m_left > 0));
      check("cyc_jojo_visible", int'(bus.jojo_visible), int'(m_visible()));
      check("cyc_game_over",    int'(bus.game_over),    int'(m_dead));
    end
  end

  // ---------------- stimulus helpers ----------------
  int frame_no = -1;
  int hit_ticks[$];

  task automatic step(int x, int y, bit j, bit m);
    bus.x             = 10'(x);
    bus.y             = 10'(y);
    bus.jojo_on       = j;
    bus.mask_crazy_on = m;
    @(posedge clk);
    model_edge(reset, x, y, j, m);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(5, 5, 1'b0, 1'b0);
    reset = 1'b0;
    frame_no = -1;
    hit_ticks.delete();
  endtask

  // mode 0: no visible overlap (boundary pixels just outside the visible
  // area are overlapped on purpose); 1: one forced visible overlap;
  // 2: random sprite flags with probability pct each.
  task automatic frame(int hold, int mode, int pct, bit ov_origin);
    int force_at;
    int x, y;
    bit j, m;
    frame_no++;
    for (int i = 0; i < hold; i++) begin
      step(0, 0, ov_origin, ov_origin);
      if (i == 0 && bus.hit_pulse) hit_ticks.push_back(frame_no);
    end
    force_at = $urandom_range(0, NPIX - 1);
    for (int p = 0; p < NPIX; p++) begin
      x = (mode == 2) ? $urandom_range(0, 799) : $urandom_range(1, 799);
      y = $urandom_range(0, 524);
      j = $urandom_range(0, 1);
      m = $urandom_range(0, 1);
      if (mode == 0 && x < 640 && y < 480) m = m & ~j;
      if (mode == 1 && p == force_at) begin
        x = $urandom_range(1, 639);
        y = $urandom_range(0, 479);
        j = 1'b1;
        m = 1'b1;
      end
      if (mode == 2) begin
        j = ($urandom_range(0, 99) < pct);
        m = ($urandom_range(0, 99) < pct);
      end
      step(x, y, j, m);
    end
    if (mode == 0) begin
      step(640, $urandom_range(0, 479), 1'b1, 1'b1);
      step($urandom_range(1, 639), 480, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int inv_frames, toggles;
    bit prev_inv, prev_vis;

    bus.x = '0; bus.y = '0; bus.jojo_on = 1'b0; bus.mask_crazy_on = 1'b0;

    // ---- 1: reset state, then ten clean frames ----
    do_reset();
    cmp_en = 1'b1;
    check("t1_reset_hp",      int'(bus.hp), 3);
    check("t1_reset_visible", int'(bus.jojo_visible), 1);
    for (int f = 0; f < 10; f++) frame($urandom_range(1, 4), 0, 0, 1'b0);
    check("t1_hp",        int'(bus.hp), 3);
    check("t1_no_hits",   hit_ticks.size(), 0);
    check("t1_game_over", int'(bus.game_over), 0);

    // ---- 2: one overlap at the last visible pixel of frame 2 ----
    do_reset();
    frame(1, 0, 0, 1'b0);
    frame(2, 0, 0, 1'b0);
    frame(1, 0, 0, 1'b0);
    step(639, 479, 1'b1, 1'b1);
    inv_frames = 0; toggles = 0; prev_inv = 0; prev_vis = 1;
    for (int k = 0; k < 70; k++) begin
      frame($urandom_range(1, 3), 0, 0, 1'b0);
      if (k == 0) check("t2_hp_after_hit", int'(bus.hp), 2);
      if (bus.invincible) begin
        inv_frames++;
        if (prev_inv && (bus.jojo_visible != prev_vis)) toggles++;
      end
      prev_inv = bus.invincible;
      prev_vis = bus.jojo_visible;
    end
    check("t2_hit_count", hit_ticks.size(), 1);
    check("t2_hit_tick",  (hit_ticks.size() > 0) ? hit_ticks[0] : -1, 3);
    check("t2_inv_frames", inv_frames, 60);
    check("t2_blink_toggles", toggles, 14);
    check("t2_hp_final", int'(bus.hp), 2);

    // ---- 3: overlap every frame until game over ----
    do_reset();
    for (int f = 0; f < 130; f++) frame($urandom_range(1, 4), 1, 0, 1'b0);
    check("t3_hit_count", hit_ticks.size(), 3);
    check("t3_hit0", (hit_ticks.size() > 0) ? hit_ticks[0] : -1, 1);
    check("t3_hit1", (hit_ticks.size() > 1) ? hit_ticks[1] : -1, 62);
    check("t3_hit2", (hit_ticks.size() > 2) ? hit_ticks[2] : -1, 123);
    check("t3_hp_zero",   int'(bus.hp), 0);
    check("t3_game_over", int'(bus.game_over), 1);
    for (int f = 0; f < 5; f++) frame(2, 1, 0, 1'b0);
    check("t3_game_over_sticky", int'(bus.game_over), 1);
    check("t3_hp_stays_zero",    int'(bus.hp), 0);
    check("t3_no_more_hits",     hit_ticks.size(), 3);

    // ---- 4: overlap on the origin pixel held for 4 clocks ----
    do_reset();
    frame(1, 0, 0, 1'b0);
    frame(1, 0, 0, 1'b0);
    frame(4, 0, 0, 1'b1);
    for (int f = 0; f < 3; f++) frame(1, 0, 0, 1'b0);
    check("t4_hit_count", hit_ticks.size(), 1);
    check("t4_hit_tick",  (hit_ticks.size() > 0) ? hit_ticks[0] : -1, 2);
    check("t4_hp",        int'(bus.hp), 2);

    // ---- 5: reset in the middle of the invincibility window ----
    do_reset();
    frame(1, 1, 0, 1'b0);
    for (int f = 0; f < 30; f++) frame(1, 0, 0, 1'b0);
    step(100, 100, 1'b1, 1'b1);
    check("t5_inv_before_reset", int'(bus.invincible), 1);
    reset = 1'b1;
    step(300, 200, 1'b1, 1'b1);
    reset = 1'b0;
    check("t5_hp",      int'(bus.hp), 3);
    check("t5_inv",     int'(bus.invincible), 0);
    check("t5_visible", int'(bus.jojo_visible), 1);
    hit_ticks.delete();
    for (int f = 0; f < 2; f++) frame(1, 0, 0, 1'b0);
    check("t5_latch_discarded", hit_ticks.size(), 0);
    check("t5_hp_after", int'(bus.hp), 3);

`ifdef JOJO_HEAL_EN
    // ---- 6: healing after HEAL_FRAMES clean alive frames ----
    do_reset();
    frame(1, 1, 0, 1'b0);
    while (frame_no < 360) frame(1, 0, 0, 1'b0);
    check("t6_hp_before_heal", int'(bus.hp), 2);
    frame(1, 0, 0, 1'b0);
    check("t6_hp_healed", int'(bus.hp), 3);
    for (int f = 0; f < 20; f++) frame(1, 0, 0, 1'b0);
    check("t6_hp_capped", int'(bus.hp), 3);
`endif

    // ---- random traffic with occasional mid-frame resets ----
    do_reset();
    for (int f = 0; f < 300; f++) begin
      int pct;
      case ($urandom_range(0, 3))
        0:       pct = 0;
        1:       pct = 5;
        2:       pct = 30;
        default: pct = 90;
      endcase
      frame($urandom_range(1, 4), 2, pct, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1;
        step($urandom_range(0, 799), $urandom_range(0, 524), 1'b1, 1'b1);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
